// File: rtl/digit_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : digit_serial_adder_if
// Description : Handshake and operand/result bundle for digit_serial_adder.
//               master drives start/a/b/cin and observes busy/done/results;
//               slave is the adder side.
// Ports       : start, a[WIDTH], b[WIDTH], cin          (master -> slave)
//               busy, done, sum[WIDTH], cout, overflow  (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface
`default_nettype wire

// File: rtl/digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : digit_serial_adder
// Description : Multi-cycle adder computing {cout,sum} = a + b + cin, DIGIT
//               bits per clock through a DIGIT-bit ripple chain with a
//               registered inter-digit carry. N = WIDTH/DIGIT cycles per add,
//               start/busy/done handshake, results held until next completion.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - digit_serial_adder_if.slave (start, a, b, cin in;
//                       busy, done, sum, cout, overflow out)
// Revision    : 1.0 - initial release
// ============================================================================
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  wire                 clk,
    input  wire                 rst_n,
    digit_serial_adder_if.slave bus
);

    localparam int c_N     = WIDTH / DIGIT;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_N - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    // Operands shift right by one digit per RUN cycle, so the digit being
    // added is always the low slice.
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_IDX_W-1:0] r_idx;

    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_run;
    logic               w_last;

    logic [DIGIT-1:0]   w_dig_a;
    logic [DIGIT-1:0]   w_dig_b;
    logic [DIGIT-1:0]   w_dig_s;
    logic [DIGIT:0]     w_c;
    logic [WIDTH-1:0]   w_res_nxt;
    logic               w_ovf;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign w_accept = bus.start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_run    = (r_state == c_ST_RUN);
    assign w_last   = w_run && (r_idx == c_IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = bus.start ? c_ST_RUN : c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // DIGIT-bit ripple-carry chain fed by the carry register
    // ------------------------------------------------------------------
    assign w_dig_a = r_a[DIGIT-1:0];
    assign w_dig_b = r_b[DIGIT-1:0];
    assign w_c[0]  = r_carry;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign w_dig_s[gi]  = w_dig_a[gi] ^ w_dig_b[gi] ^ w_c[gi];
            assign w_c[gi + 1]  = (w_dig_a[gi] & w_dig_b[gi])
                                | (w_c[gi] & (w_dig_a[gi] ^ w_dig_b[gi]));
        end
    endgenerate

    // On the final digit the slice holds the operand MSBs, so overflow is
    // judged from that slice alone.
    assign w_ovf = (w_dig_a[DIGIT-1] == w_dig_b[DIGIT-1])
                && (w_dig_s[DIGIT-1] != w_dig_a[DIGIT-1]);

    // ------------------------------------------------------------------
    // Partial-result register: each new digit enters at the top and the
    // earlier digits move down, so after N digits the word is aligned.
    // With a single digit there is nothing to accumulate.
    // ------------------------------------------------------------------
    generate
        if (c_N > 1) begin : g_res_shift
            logic [WIDTH-DIGIT-1:0] r_res;

            assign w_res_nxt = {w_dig_s, r_res};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_res <= '0;
                end else if (w_run) begin
                    r_res <= w_res_nxt[WIDTH-1:DIGIT];
                end
            end
        end else begin : g_res_single
            assign w_res_nxt = w_dig_s;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= bus.a;
                r_b     <= bus.b;
                r_carry <= bus.cin;
                r_idx   <= '0;
            end else if (w_run) begin
                r_a     <= r_a >> DIGIT;
                r_b     <= r_b >> DIGIT;
                r_carry <= w_c[DIGIT];
                r_idx   <= r_idx + c_IDX_W'(1);
                if (w_last) begin
                    r_sum  <= w_res_nxt;
                    r_cout <= w_c[DIGIT];
                    r_ovf  <= w_ovf;
                end
            end
        end
    end

    assign bus.busy     = (r_state == c_ST_RUN);
    assign bus.done     = (r_state == c_ST_DONE);
    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_serial_adder
// Description : Self-checking bench for digit_serial_adder. One 16/4 instance
//               for directed, handshake, reset and random tests; three 4-bit
//               instances (DIGIT 1, 2, 4) swept exhaustively in parallel.
//               Expected values come from integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [15:0] prev_sum;
    logic        prev_cout;
    logic        prev_ovf;

    always #5 clk = ~clk;

    digit_serial_adder_if #(.WIDTH(16)) bus16 ();
    digit_serial_adder_if #(.WIDTH(4))  bus_d1 ();
    digit_serial_adder_if #(.WIDTH(4))  bus_d2 ();
    digit_serial_adder_if #(.WIDTH(4))  bus_d4 ();

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    digit_serial_adder #(.WIDTH(4),  .DIGIT(1)) u_dut_d1 (.clk(clk), .rst_n(rst_n), .bus(bus_d1));
    digit_serial_adder #(.WIDTH(4),  .DIGIT(2)) u_dut_d2 (.clk(clk), .rst_n(rst_n), .bus(bus_d2));
    digit_serial_adder #(.WIDTH(4),  .DIGIT(4)) u_dut_d4 (.clk(clk), .rst_n(rst_n), .bus(bus_d4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Two's-complement overflow judged by range of the signed total.
    function automatic bit ref_ovf(int w, int a, int b, int c);
        int sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        int sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        int t  = sa + sb + c;
        return (t > ((1 << (w - 1)) - 1)) || (t < -(1 << (w - 1)));
    endfunction

    // One add on the 16-bit instance; optionally pokes start with other
    // operands during RUN, which must be ignored.
    task automatic do_add(input logic [15:0] a_in, input logic [15:0] b_in,
                          input logic c_in, input bit poke);
        logic [31:0] s;
        bit          e_ovf;
        int          lat;
        int          busy_cnt;
        s     = 32'(a_in) + 32'(b_in) + 32'(c_in);
        e_ovf = ref_ovf(16, int'(a_in), int'(b_in), int'(c_in));
        bus16.a     = a_in;
        bus16.b     = b_in;
        bus16.cin   = c_in;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        bus16.a     = 16'($urandom);
        bus16.b     = 16'($urandom);
        bus16.cin   = 1'($urandom);
        lat      = 0;
        busy_cnt = 0;
        while (!bus16.done && lat < 20) begin
            if (bus16.busy) busy_cnt++;
            check("hold_sum", {15'd0, bus16.cout, bus16.sum}, {15'd0, prev_cout, prev_sum});
            check("hold_ovf", bus16.overflow, prev_ovf);
            if (poke && lat == 1) begin
                bus16.start = 1'b1;
                bus16.a     = ~a_in;
                bus16.b     = b_in ^ 16'h5A5A;
            end else begin
                bus16.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus16.start = 1'b0;
        check("latency", lat, 4);
        check("busy_cycles", busy_cnt, 4);
        check("busy_at_done", bus16.busy, 0);
        check("sum", bus16.sum, s[15:0]);
        check("cout", bus16.cout, s[16]);
        check("overflow", bus16.overflow, e_ovf);
        prev_sum  = s[15:0];
        prev_cout = s[16];
        prev_ovf  = e_ovf;
    endtask

    initial begin
        int          done_cnt;
        int          last_k;
        int          quiet;
        logic [31:0] s;
        int          lat1, lat2, lat4;
        logic [4:0]  r1, r2, r4;
        logic        o1, o2, o4;

        rst_n = 1'b1;
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
        bus_d1.start = 1'b0; bus_d1.a = '0; bus_d1.b = '0; bus_d1.cin = 1'b0;
        bus_d2.start = 1'b0; bus_d2.a = '0; bus_d2.b = '0; bus_d2.cin = 1'b0;
        bus_d4.start = 1'b0; bus_d4.a = '0; bus_d4.b = '0; bus_d4.cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", bus16.busy, 0);
        check("rst_done", bus16.done, 0);
        check("rst_sum", bus16.sum, 0);
        check("rst_cout", bus16.cout, 0);
        check("rst_ovf", bus16.overflow, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic cases
        do_add(16'h1234, 16'h4321, 1'b0, 1'b0);
        do_add(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_add(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        do_add(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        do_add(16'h8000, 16'h8000, 1'b0, 1'b0);
        do_add(16'h0F0F, 16'h1111, 1'b1, 1'b1);

        // Random operands, with random start pokes during RUN
        for (int i = 0; i < 16; i++) begin
            do_add(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        // start held high: a new add every DONE cycle, done every 5 cycles
        bus16.a = 16'hABCD; bus16.b = 16'h1357; bus16.cin = 1'b1;
        bus16.start = 1'b1;
        s = 32'h0000ABCD + 32'h00001357 + 32'd1;
        done_cnt = 0;
        last_k   = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check("busy_done_excl", bus16.busy & bus16.done, 0);
            if (bus16.done) begin
                if (last_k >= 0) check("restart_period", k - last_k, 5);
                check("held_sum", bus16.sum, s[15:0]);
                last_k = k;
                done_cnt++;
            end
        end
        bus16.start = 1'b0;
        check("held_done_count", done_cnt, 4);
        prev_sum = s[15:0]; prev_cout = s[16];
        prev_ovf = ref_ovf(16, 32'hABCD, 32'h1357, 1);
        @(posedge clk); #1;

        // Asynchronous reset in the second RUN cycle
        bus16.a = 16'hF0F0; bus16.b = 16'h0F0F; bus16.cin = 1'b1;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus16.busy, 0);
        check("mid_rst_done", bus16.done, 0);
        check("mid_rst_sum", bus16.sum, 0);
        check("mid_rst_cout", bus16.cout, 0);
        check("mid_rst_ovf", bus16.overflow, 0);
        @(negedge clk) rst_n = 1'b1;
        quiet = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            quiet += int'(bus16.done) + int'(bus16.busy);
        end
        check("no_done_after_rst", quiet, 0);
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        do_add(16'hC3A5, 16'h5A3C, 1'b1, 1'b0);

        // Exhaustive 4-bit sweep on DIGIT = 1, 2, 4 in parallel
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    bus_d1.a = 4'(ia); bus_d1.b = 4'(ib); bus_d1.cin = 1'(ic); bus_d1.start = 1'b1;
                    bus_d2.a = 4'(ia); bus_d2.b = 4'(ib); bus_d2.cin = 1'(ic); bus_d2.start = 1'b1;
                    bus_d4.a = 4'(ia); bus_d4.b = 4'(ib); bus_d4.cin = 1'(ic); bus_d4.start = 1'b1;
                    @(posedge clk); #1;
                    bus_d1.start = 1'b0; bus_d2.start = 1'b0; bus_d4.start = 1'b0;
                    lat1 = -1; lat2 = -1; lat4 = -1;
                    r1 = '0; r2 = '0; r4 = '0; o1 = 1'b0; o2 = 1'b0; o4 = 1'b0;
                    for (int k = 1; k <= 6; k++) begin
                        @(posedge clk); #1;
                        if (bus_d1.done && lat1 < 0) begin
                            lat1 = k; r1 = {bus_d1.cout, bus_d1.sum}; o1 = bus_d1.overflow;
                        end
                        if (bus_d2.done && lat2 < 0) begin
                            lat2 = k; r2 = {bus_d2.cout, bus_d2.sum}; o2 = bus_d2.overflow;
                        end
                        if (bus_d4.done && lat4 < 0) begin
                            lat4 = k; r4 = {bus_d4.cout, bus_d4.sum}; o4 = bus_d4.overflow;
                        end
                    end
                    s = 32'(ia + ib + ic);
                    check("w4d1_latency", lat1, 4);
                    check("w4d2_latency", lat2, 2);
                    check("w4d4_latency", lat4, 1);
                    check("w4d1_result", r1, s[4:0]);
                    check("w4d2_result", r2, s[4:0]);
                    check("w4d4_result", r4, s[4:0]);
                    check("w4d1_ovf", o1, ref_ovf(4, ia, ib, ic));
                    check("w4d2_ovf", o2, ref_ovf(4, ia, ib, ic));
                    check("w4d4_ovf", o4, ref_ovf(4, ia, ib, ic));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
